// File: rtl/module_cla_word_sequencer.sv
// Multi-cycle wide adder: one CLA slice reused per word, LSW first, carry chained in a register.
// Optional CLA_SEQ_SUB_EN adds sub_i for A-B (B inverted, initial carry forced to 1).

module module_carry_look_ahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             acc;
    logic             pp;

    // Every carry is a flat sum of generate terms, not a ripple chain.
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        c[0] = carry_i;
        acc  = 1'b0;
        pp   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & carry_i);
        end
        sum_o   = p ^ c[WIDTH-1:0];
        carry_o = c[WIDTH];
    end

endmodule

module module_cla_word_sequencer #(
    parameter int CLA_WIDTH = 8,
    parameter int WORDS     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WORDS*CLA_WIDTH-1:0] a_i,
    input  logic [WORDS*CLA_WIDTH-1:0] b_i,
    input  logic                       carry_i,
`ifdef CLA_SEQ_SUB_EN
    input  logic                       sub_i,
`endif
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WORDS*CLA_WIDTH-1:0] sum_o,
    output logic                       carry_o,
    output logic                       busy_o
);

    localparam int W  = WORDS * CLA_WIDTH;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic                 sub_in;
    logic [CLA_WIDTH-1:0] a_word;
    logic [CLA_WIDTH-1:0] b_word;
    logic [CLA_WIDTH-1:0] s_sum;
    logic                 s_cout;

`ifdef CLA_SEQ_SUB_EN
    assign sub_in = sub_i;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        a_word = a_q[int'(cnt_q)*CLA_WIDTH +: CLA_WIDTH];
        b_word = b_q[int'(cnt_q)*CLA_WIDTH +: CLA_WIDTH];
        if (sub_q) begin
            b_word = ~b_word;
        end
    end

    module_carry_look_ahead_adder #(
        .WIDTH(CLA_WIDTH)
    ) u_slice (
        .a_i    (a_word),
        .b_i    (b_word),
        .carry_i(carry_q),
        .sum_o  (s_sum),
        .carry_o(s_cout)
    );

    // Words build up in acc; sum_q only updates on entry to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                    carry_d = sub_in ? 1'b1 : carry_i;
                end
            end
            S_RUN: begin
                acc_d[int'(cnt_q)*CLA_WIDTH +: CLA_WIDTH] = s_sum;
                carry_d = s_cout;
                if (cnt_q == CW'(WORDS - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = s_cout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign sum_o       = sum_q;
    assign carry_o     = cout_q;

endmodule

// File: tb/tb_module_cla_word_sequencer.sv
// Directed and randomized checks of module_cla_word_sequencer (CLA_WIDTH=8, WORDS=4)
// against an arithmetic reference model; build with +define+CLA_SEQ_SUB_EN to cover subtraction.

module tb_module_cla_word_sequencer;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        carry_i;
`ifdef CLA_SEQ_SUB_EN
    logic        sub_i;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum_o;
    logic        carry_o;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int accepts = 0;
    int ops   = 0;

    logic [31:0] prev_sum;
    logic        prev_c;
    logic [32:0] exp_q[$];

    module_cla_word_sequencer #(
        .CLA_WIDTH(8),
        .WORDS    (WORDS)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a_i),
        .b_i        (b_i),
        .carry_i    (carry_i),
`ifdef CLA_SEQ_SUB_EN
        .sub_i      (sub_i),
`endif
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum_o),
        .carry_o    (carry_o),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) accepts++;
    end

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic s);
        a_i      = a;
        b_i      = b;
        carry_i  = c;
`ifdef CLA_SEQ_SUB_EN
        sub_i    = s;
`endif
        in_valid = 1'b1;
        ops++;
        exp_q.push_back(model(a, b, c, s));
    endtask

    task automatic accept();
        int n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 64), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i      = $urandom;
        b_i      = $urandom;
        carry_i  = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
        sub_i    = 1'($urandom);
`endif
    endtask

    task automatic wait_result();
        int n = 0;
        bit ok = 1'b1;
        logic [32:0] e;
        do begin
            @(negedge clk);
            n++;
            if (out_valid !== 1'b1) begin
                if (in_ready !== 1'b0 || busy !== 1'b1 ||
                    sum_o !== prev_sum || carry_o !== prev_c) ok = 1'b0;
            end
        end while (out_valid !== 1'b1 && n < 64);
        chk("run_hold", 64'(ok), 64'd1);
        chk("latency", 64'(n), 64'(WORDS + 1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        chk("sum", 64'(sum_o), 64'(e[31:0]));
        chk("carry", 64'(carry_o), 64'(e[32]));
        prev_sum = e[31:0];
        prev_c   = e[32];
    endtask

    task automatic release_result(input int rgap, input bit early,
                                  input logic [31:0] na, input logic [31:0] nb,
                                  input logic nc, input logic ns);
        bit ok = 1'b1;
        for (int i = 0; i < rgap; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                sum_o !== prev_sum || carry_o !== prev_c) ok = 1'b0;
            if (early && i == rgap - 1) present(na, nb, nc, ns);
        end
        if (early && rgap == 0) present(na, nb, nc, ns);
        chk("done_hold", 64'(ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_sum", 64'(sum_o), 64'(prev_sum));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        bit          pre, early;
        int          gap, rgap;
        bit          ok;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        carry_i   = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub_i     = 1'b0;
`endif
        prev_sum  = '0;
        prev_c    = 1'b0;
        #12;
        chk("rst_sum", 64'(sum_o), 64'd0);
        chk("rst_carry", 64'(carry_o), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        present(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        accept();
        wait_result();
        chk("t1_sum", 64'(sum_o), 64'h0);
        chk("t1_carry", 64'(carry_o), 64'd1);
        release_result(0, 1'b0, '0, '0, 1'b0, 1'b0);

        present(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        accept();
        wait_result();
        chk("t2_sum", 64'(sum_o), 64'h2345_678A);
        chk("t2_carry", 64'(carry_o), 64'd0);
        release_result(0, 1'b0, '0, '0, 1'b0, 1'b0);

        present($urandom, $urandom, 1'($urandom), 1'b0);
        accept();
        wait_result();
        release_result(3, 1'b0, '0, '0, 1'b0, 1'b0);

        present(32'hA0A0_A0A0, 32'h0F0F_0F0F, 1'b1, 1'b0);
        accept();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_sum", 64'(sum_o), 64'd0);
        chk("abort_carry", 64'(carry_o), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_valid", 64'(ok), 64'd1);
        rst_n    = 1'b1;
        prev_sum = '0;
        prev_c   = 1'b0;
        @(negedge clk);
        present(32'd1, 32'd2, 1'b0, 1'b0);
        accept();
        wait_result();
        chk("t4_sum", 64'(sum_o), 64'h3);
        release_result(0, 1'b0, '0, '0, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        present(32'd5, 32'd7, 1'b0, 1'b1);
        accept();
        wait_result();
        chk("t5a_sum", 64'(sum_o), 64'hFFFF_FFFE);
        chk("t5a_carry", 64'(carry_o), 64'd0);
        release_result(0, 1'b0, '0, '0, 1'b0, 1'b0);
        present(32'd7, 32'd5, 1'b1, 1'b1);
        accept();
        wait_result();
        chk("t5b_sum", 64'(sum_o), 64'h2);
        chk("t5b_carry", 64'(carry_o), 64'd1);
        release_result(0, 1'b0, '0, '0, 1'b0, 1'b0);
`endif

        pre = 1'b0;
        ra  = $urandom;
        rb  = $urandom;
        rc  = 1'($urandom);
        rs  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!pre) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                present(ra, rb, rc, rs);
            end
            accept();
            wait_result();
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom);
`endif
            early = (k < 199) ? 1'($urandom) : 1'b0;
            rgap  = $urandom_range(0, 3);
            release_result(rgap, early, ra, rb, rc, rs);
            pre = early;
        end

        repeat (2) @(negedge clk);
        chk("one_accept_per_op", 64'(accepts), 64'(ops));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
